// File: rtl/jk_bank_arbiter_if.sv
// Request/acknowledge bundle between two requesters and the JK bank arbiter.
interface jk_bank_arbiter_if #(
    parameter int unsigned IDX_W = 2
);
    logic             req_a;
    logic             req_b;
    logic [1:0]       op_a;
    logic [1:0]       op_b;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    logic             ack_a;
    logic             ack_b;
    logic             err;
    logic             busy;
    logic             grant_b;

    modport master (
        output req_a, req_b, op_a, op_b, idx_a, idx_b,
        input  ack_a, ack_b, err, busy, grant_b
    );

    modport slave (
        input  req_a, req_b, op_a, op_b, idx_a, idx_b,
        output ack_a, ack_b, err, busy, grant_b
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Two-requester arbiter that sequences single-cell JK commands onto a JK bank.
// Optional macro JKARB_FIXED_PRIO_EN: requester A always wins a tie (default round-robin).
module jk_bank_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    jk_bank_arbiter_if.slave bus,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic             grant_q;
    logic [WIDTH-1:0] q_q;
    logic             ack_a_q;
    logic             ack_b_q;
    logic             err_q;
    logic             busy_q;

    logic [1:0]       op_d;
    logic [IDX_W-1:0] idx_d;
    logic             grant_d;
    logic [WIDTH-1:0] q_d;
    logic             ack_a_d;
    logic             ack_b_d;
    logic             err_d;
    logic             busy_d;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             in_range;

    // A requester is still holding req during its own ack cycle; that is not a new request.
    logic eff_a;
    logic eff_b;
    logic win_b;

    assign eff_a = bus.req_a & ~ack_a_q;
    assign eff_b = bus.req_b & ~ack_b_q;

`ifdef JKARB_FIXED_PRIO_EN
    assign win_b = eff_b & ~eff_a;
`else
    assign win_b = eff_b & (~eff_a | ~grant_q);
`endif

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (eff_a || eff_b) state_nxt = APPLY;
            APPLY:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the command latch
    always_comb begin
        op_d     = op_q;
        idx_d    = idx_q;
        grant_d  = grant_q;
        q_d      = q_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        err_d    = 1'b0;
        j_vec    = '0;
        k_vec    = '0;
        in_range = 32'(idx_q) < WIDTH;
        busy_d   = (state != IDLE) || (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (state_nxt == APPLY) begin
                    grant_d = win_b;
                    op_d    = win_b ? bus.op_b  : bus.op_a;
                    idx_d   = win_b ? bus.idx_b : bus.idx_a;
                end
            end
            APPLY: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (in_range && (idx_q == IDX_W'(i))) begin
                        j_vec[i] = op_q[1];
                        k_vec[i] = op_q[0];
                    end
                end
                q_d = (j_vec & ~q_q) | (~k_vec & q_q);
            end
            ACK: begin
                ack_a_d = ~grant_q;
                ack_b_d = grant_q;
                err_d   = ~in_range;
            end
            default: ;
        endcase
    end

    // Output and command registers; last-grant resets to B so A wins the first tie
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            op_q    <= 2'b00;
            idx_q   <= '0;
            grant_q <= 1'b1;
            q_q     <= '0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            q_q     <= q_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack_a   = ack_a_q;
    assign bus.ack_b   = ack_b_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.grant_b = grant_q;
    assign Q           = q_q;
    assign QN          = ~q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: directed spec scenarios plus random two-requester traffic.
module tb_jk_bank_arbiter;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned IDX_W = 3;

    logic             Clock;
    logic             Resetn;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QN;

    jk_bank_arbiter_if #(.IDX_W(IDX_W)) bus ();

    jk_bank_arbiter #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus),
        .Q      (Q),
        .QN     (QN)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        bit         owner_b;
        bit         err;
        logic [3:0] q;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_ack_cyc = 0;

    // Reference model: bank contents as plain bits plus who was granted last
    bit mq[WIDTH];
    bit last_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_q();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i] = mq[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) mq[i] = 1'b0;
        last_b = 1'b1;
        sb.delete();
    endtask

    // Commands: 00 keep, 01 clear, 10 set, 11 invert; an index beyond the bank only flags err
    task automatic model_apply(input bit b, input logic [1:0] op, input int idx, input int gap);
        exp_t e;
        bit   er;
        er = (idx >= int'(WIDTH));
        if (!er) begin
            case (op)
                2'b01:   mq[idx] = 1'b0;
                2'b10:   mq[idx] = 1'b1;
                2'b11:   mq[idx] = !mq[idx];
                default: ;
            endcase
        end
        last_b    = b;
        e.owner_b = b;
        e.err     = er;
        e.q       = model_q();
        e.gap     = gap;
        sb.push_back(e);
    endtask

    // Monitor: every ack pops one expected completion
    always @(negedge Clock) begin
        cyc++;
        if (Resetn === 1'b1 && (bus.ack_a === 1'b1 || bus.ack_b === 1'b1)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack_a=%0b ack_b=%0b expected none", bus.ack_a, bus.ack_b);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_owner", {30'd0, bus.ack_a, bus.ack_b}, e.owner_b ? 32'd1 : 32'd2);
                check("ack_err", {31'd0, bus.err}, {31'd0, e.err});
                check("ack_q", {28'd0, Q}, {28'd0, e.q});
                check("ack_qn", {28'd0, QN}, {28'd0, ~e.q});
                check("ack_grant_b", {31'd0, bus.grant_b}, {31'd0, e.owner_b});
                if (e.gap > 0) check("ack_gap", cyc - last_ack_cyc, e.gap);
            end
            last_ack_cyc = cyc;
        end
    end

    // One round of requests; entered and left at 1 time unit after a rising edge
    task automatic round(input bit ua, input bit ub, input logic [1:0] oa, input logic [1:0] ob,
                         input logic [IDX_W-1:0] ia, input logic [IDX_W-1:0] ib);
        bit first_b;
        bit sa;
        bit sbk;
        int n;
        bus.req_a = ua; bus.op_a = oa; bus.idx_a = ia;
        bus.req_b = ub; bus.op_b = ob; bus.idx_b = ib;
        if (ua && ub) begin
`ifdef JKARB_FIXED_PRIO_EN
            first_b = 1'b0;
`else
            first_b = !last_b;
`endif
            model_apply(first_b, first_b ? ob : oa, first_b ? int'(ib) : int'(ia), 0);
            model_apply(!first_b, first_b ? oa : ob, first_b ? int'(ia) : int'(ib), 3);
        end else if (ua) begin
            model_apply(1'b0, oa, int'(ia), 0);
        end else if (ub) begin
            model_apply(1'b1, ob, int'(ib), 0);
        end
        n = 0;
        while ((bus.req_a || bus.req_b) && n < 20) begin
            @(negedge Clock);
            sa  = bus.ack_a;
            sbk = bus.ack_b;
            @(posedge Clock);
            #1;
            if (sa)  bus.req_a = 1'b0;
            if (sbk) bus.req_b = 1'b0;
            // After the grant edge the lone requester's op/idx no longer matter
            if (n == 0 && !(ua && ub)) begin
                if (ua) begin bus.op_a = 2'($urandom_range(0, 3)); bus.idx_a = IDX_W'($urandom); end
                if (ub) begin bus.op_b = 2'($urandom_range(0, 3)); bus.idx_b = IDX_W'($urandom); end
            end
            n++;
        end
        if (bus.req_a || bus.req_b) begin
            total++;
            bad++;
            $display("FAIL round_timeout: got req_a=%0b req_b=%0b still waiting, expected acks", bus.req_a, bus.req_b);
            bus.req_a = 1'b0;
            bus.req_b = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [IDX_W-1:0] rand_idx();
        if ($urandom_range(0, 7) == 0) return IDX_W'(4 + $urandom_range(0, 3));
        return IDX_W'($urandom_range(0, 3));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        Resetn = 1'b0;
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        bus.op_a = 2'b00; bus.op_b = 2'b00;
        bus.idx_a = '0;   bus.idx_b = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_q", {28'd0, Q}, 32'h0);
        check("rst_qn", {28'd0, QN}, 32'hF);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_acks", {30'd0, bus.ack_a, bus.ack_b}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_grant_b", {31'd0, bus.grant_b}, 32'd1);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        // A sets cell 2 with exact cycle timing
        bus.req_a = 1'b1; bus.op_a = 2'b10; bus.idx_a = 3'd2;
        model_apply(1'b0, 2'b10, 2, 0);
        @(posedge Clock); @(negedge Clock);
        check("t0_busy", {31'd0, bus.busy}, 32'd1);
        check("t0_q", {28'd0, Q}, 32'h0);
        @(posedge Clock); @(negedge Clock);
        check("t1_q", {28'd0, Q}, 32'h4);
        check("t1_ack_a", {31'd0, bus.ack_a}, 32'd0);
        @(posedge Clock); @(negedge Clock);
        check("t2_ack_a", {31'd0, bus.ack_a}, 32'd1);
        check("t2_ack_b", {31'd0, bus.ack_b}, 32'd0);
        check("t2_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge Clock); #1;
        bus.req_a = 1'b0;
        @(negedge Clock);
        check("t3_busy", {31'd0, bus.busy}, 32'd0);
        check("t3_ack_a", {31'd0, bus.ack_a}, 32'd0);
        @(posedge Clock); #1;

        // Tie after reset: A set 0 first, then B toggle 0
        do_reset();
        round(1'b1, 1'b1, 2'b10, 2'b11, 3'd0, 3'd0);
        @(negedge Clock);
        check("tie_q0", {31'd0, Q[0]}, 32'd0);
        @(posedge Clock); #1;

        // Four toggles of cell 1 from A
        for (int k = 0; k < 4; k++) begin
            round(1'b1, 1'b0, 2'b11, 2'b00, 3'd1, 3'd0);
            @(negedge Clock);
            check("tog_q1", {31'd0, Q[1]}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("tog_qn1", {31'd0, QN[1]}, (k % 2 == 0) ? 32'd0 : 32'd1);
            @(posedge Clock); #1;
        end

        // Out-of-range index from B
        round(1'b0, 1'b1, 2'b00, 2'b10, 3'd0, 3'd5);
        @(negedge Clock);
        check("oor_q", {28'd0, Q}, 32'h0);
        @(posedge Clock); #1;

        // Hold on a set cell
        round(1'b1, 1'b0, 2'b10, 2'b00, 3'd1, 3'd0);
        round(1'b1, 1'b0, 2'b00, 2'b00, 3'd1, 3'd0);
        @(negedge Clock);
        check("hold_q", {28'd0, Q}, 32'h2);
        @(posedge Clock); #1;

        // Reset during APPLY of A's set on cell 3
        bus.req_a = 1'b1; bus.op_a = 2'b10; bus.idx_a = 3'd3;
        @(posedge Clock); @(negedge Clock);
        Resetn = 1'b0;
        #1;
        check("rsta_q", {28'd0, Q}, 32'h0);
        check("rsta_qn", {28'd0, QN}, 32'hF);
        check("rsta_busy", {31'd0, bus.busy}, 32'd0);
        bus.req_a = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock);
        check("rsta_ack", {30'd0, bus.ack_a, bus.ack_b}, 32'd0);
        Resetn = 1'b1;
        @(posedge Clock); #1;
        round(1'b1, 1'b0, 2'b10, 2'b00, 3'd0, 3'd0);

        // Reset after the APPLY edge wipes the fresh update and suppresses the ack
        bus.req_a = 1'b1; bus.op_a = 2'b10; bus.idx_a = 3'd3;
        @(posedge Clock); @(posedge Clock); @(negedge Clock);
        check("rstk_pre_q", {28'd0, Q}, 32'h9);
        Resetn = 1'b0;
        #1;
        check("rstk_q", {28'd0, Q}, 32'h0);
        check("rstk_busy", {31'd0, bus.busy}, 32'd0);
        bus.req_a = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock);
        check("rstk_ack", {30'd0, bus.ack_a, bus.ack_b}, 32'd0);
        Resetn = 1'b1;
        @(posedge Clock); #1;
        round(1'b1, 1'b0, 2'b10, 2'b00, 3'd3, 3'd0);

        // Random traffic
        for (int r = 0; r < 150; r++) begin
            int  sel;
            sel = int'($urandom_range(0, 2));
            round(sel != 1, sel != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  rand_idx(), rand_idx());
            repeat ($urandom_range(0, 2)) begin
                @(posedge Clock); #1;
            end
        end

        repeat (4) @(posedge Clock);
        check("sb_drain", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
